// File: rtl/csr_unit_if.sv
// Bundles the pipeline-side read, write, trap and interrupt signals of the CSR unit.
// The master modport is the pipeline. The slave modport is the CSR unit.
interface csr_unit_if #(
  parameter int XLEN    = 32,
  parameter int NUM_HPM = 2
);
  localparam int HW = (NUM_HPM > 0) ? NUM_HPM : 1;

  logic [11:0]     rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            rd_illegal;
  logic [1:0]      wr_op;
  logic [11:0]     wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            trap_req;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_val;
  logic            mret;
  logic            instret;
  logic [HW-1:0]   hpm_event;
  logic            irq_sw;
  logic            irq_timer;
  logic            irq_ext;
  logic            irq_pending;
  logic [XLEN-1:0] irq_cause;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] epc;

  modport master (
    output rd_addr, wr_op, wr_addr, wr_data, trap_req, trap_cause, trap_pc, trap_val,
           mret, instret, hpm_event, irq_sw, irq_timer, irq_ext,
    input  rd_data, rd_illegal, irq_pending, irq_cause, trap_vector, epc
  );

  modport slave (
    input  rd_addr, wr_op, wr_addr, wr_data, trap_req, trap_cause, trap_pc, trap_val,
           mret, instret, hpm_event, irq_sw, irq_timer, irq_ext,
    output rd_data, rd_illegal, irq_pending, irq_cause, trap_vector, epc
  );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file: atomic RW/RS/RC, trap/mret stacking, irq arbitration, 64-bit counters.
// Latency: reads combinational; writes, traps and mret visible the cycle after their edge.
// Backpressure: none, every request is accepted in the cycle it is presented.
module csr_unit #(
  parameter int          XLEN     = 32,
  parameter int          NUM_HPM  = 2,
  parameter int          HART_ID  = 0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0120,
  parameter int          VECTORED = 1
) (
  input logic        clk,
  input logic        rst_n,
  csr_unit_if.slave  bus
);
  localparam int NCNT = NUM_HPM + 2;
  localparam logic [XLEN-1:0] MIE_MASK = 32'h0000_0888;
  localparam logic [XLEN-1:0] INH_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

  logic            mstatus_mie, mstatus_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mcountinhibit_q;
  logic [2:0]      mip_q;  // {ext, timer, sw}
  logic [63:0]     cnt_q [NCNT];

  logic [XLEN-1:0] mstatus_val, mip_val, wr_val;
  logic [XLEN:0]   rd_pack, wr_pack;
  logic            wr_en;
  logic [NCNT-1:0] cnt_evt, cnt_inh;
  logic [2:0]      irq_en;

  assign mstatus_val = XLEN'({2'b11, 3'b000, mstatus_mpie, 3'b000, mstatus_mie, 3'b000});
  assign mip_val     = XLEN'({mip_q[2], 3'b000, mip_q[1], 3'b000, mip_q[0], 3'b000});

  // Counter k lives at offset 0 (mcycle), 2 (minstret) or k+1 (hpm); offset 1 is the unimplemented time CSR.
  function automatic logic [11:0] cnt_off(input int k);
    return (k == 0) ? 12'h000 : 12'(k + 1);
  endfunction

  function automatic logic [XLEN-1:0] csr_op(input logic [1:0] op, input logic [XLEN-1:0] old,
                                              input logic [XLEN-1:0] d);
    case (op)
      2'b01:   return d;
      2'b10:   return old | d;
      2'b11:   return old & ~d;
      default: return old;
    endcase
  endfunction

  function automatic logic [XLEN:0] csr_rd(input logic [11:0] a);
    logic [XLEN-1:0] d;
    logic            ill;
    d   = '0;
    ill = 1'b0;
    case (a)
      12'h300: d = mstatus_val;
      12'h301: d = MISA_VAL;
      12'h304: d = mie_q;
      12'h305: d = mtvec_q;
      12'h320: d = mcountinhibit_q;
      12'h340: d = mscratch_q;
      12'h341: d = mepc_q;
      12'h342: d = mcause_q;
      12'h343: d = mtval_q;
      12'h344: d = mip_val;
      12'hF14: d = XLEN'(HART_ID);
      default: begin
        ill = 1'b1;
        for (int k = 0; k < NCNT; k++) begin
          if (a == 12'hB00 + cnt_off(k) || a == 12'hC00 + cnt_off(k)) begin
            d   = cnt_q[k][31:0];
            ill = 1'b0;
          end
          if (a == 12'hB80 + cnt_off(k) || a == 12'hC80 + cnt_off(k)) begin
            d   = cnt_q[k][63:32];
            ill = 1'b0;
          end
        end
      end
    endcase
    return {ill, d};
  endfunction

  always_comb begin
    rd_pack = csr_rd(bus.rd_addr);
    wr_pack = csr_rd(bus.wr_addr);
    wr_val  = csr_op(bus.wr_op, wr_pack[XLEN-1:0], bus.wr_data);
    wr_en   = (bus.wr_op != 2'b00) && !wr_pack[XLEN] && !bus.trap_req && !bus.mret;
  end

  assign bus.rd_data    = rd_pack[XLEN-1:0];
  assign bus.rd_illegal = rd_pack[XLEN];
  assign bus.epc        = mepc_q;

  always_comb begin
    cnt_evt    = '0;
    cnt_inh    = '0;
    cnt_evt[0] = 1'b1;
    cnt_evt[1] = bus.instret;
    cnt_inh[0] = mcountinhibit_q[0];
    cnt_inh[1] = mcountinhibit_q[2];
    for (int i = 0; i < NUM_HPM; i++) begin
      cnt_evt[2+i] = bus.hpm_event[i];
      cnt_inh[2+i] = mcountinhibit_q[3+i];
    end
  end

  always_comb begin
    irq_en          = mip_q & {mie_q[11], mie_q[7], mie_q[3]};
    bus.irq_pending = mstatus_mie && (irq_en != 3'b000);
    bus.irq_cause   = '0;
    if (bus.irq_pending) begin
      if (irq_en[2])      bus.irq_cause = 32'h8000_000B;
      else if (irq_en[0]) bus.irq_cause = 32'h8000_0003;
      else                bus.irq_cause = 32'h8000_0007;
    end
    bus.trap_vector = {mtvec_q[XLEN-1:2], 2'b00};
    if (mtvec_q[0] && (VECTORED != 0) && bus.trap_cause[XLEN-1])
      bus.trap_vector = {mtvec_q[XLEN-1:2], 2'b00} + XLEN'({bus.trap_cause[4:0], 2'b00});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_mie     <= 1'b0;
      mstatus_mpie    <= 1'b0;
      mie_q           <= '0;
      mtvec_q         <= '0;
      mscratch_q      <= '0;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
      mcountinhibit_q <= '0;
      mip_q           <= '0;
      for (int k = 0; k < NCNT; k++) cnt_q[k] <= '0;
    end else begin
      mip_q <= {bus.irq_ext, bus.irq_timer, bus.irq_sw};
      // A write to either half wins over the increment; the other half is left untouched.
      for (int k = 0; k < NCNT; k++) begin
        if (wr_en && bus.wr_addr == 12'hB00 + cnt_off(k))
          cnt_q[k][31:0] <= wr_val;
        else if (wr_en && bus.wr_addr == 12'hB80 + cnt_off(k))
          cnt_q[k][63:32] <= wr_val;
        else if (cnt_evt[k] && !cnt_inh[k])
          cnt_q[k] <= cnt_q[k] + 64'd1;
      end
      if (bus.trap_req) begin
        mepc_q       <= {bus.trap_pc[XLEN-1:1], 1'b0};
        mcause_q     <= bus.trap_cause;
        mtval_q      <= bus.trap_val;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (bus.mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wr_en) begin
        case (bus.wr_addr)
          12'h300: begin
            mstatus_mie  <= wr_val[3];
            mstatus_mpie <= wr_val[7];
          end
          12'h304: mie_q           <= wr_val & MIE_MASK;
          12'h305: mtvec_q         <= {wr_val[XLEN-1:2], 1'b0,
                                       (wr_val[1:0] == 2'b01) && (VECTORED != 0)};
          12'h320: mcountinhibit_q <= wr_val & INH_MASK;
          12'h340: mscratch_q      <= wr_val;
          12'h341: mepc_q          <= {wr_val[XLEN-1:1], 1'b0};
          12'h342: mcause_q        <= wr_val;
          12'h343: mtval_q         <= wr_val;
          default: ;
        endcase
      end
    end
  end
endmodule
